pipeline_hazard_ctrl: RTL and testbench

Central stall/flush scheduler for the 5-stage RV32 pipeline (IF, Dec, Exec, Mem, WB). It merges the stall and redirect requests: decode-stage branch/JALR operand wait, decode redirect (npc_control), Exec load-use hazards, data-memory busy and a halt instruction. From these it drives per-stage stall, flush and bubble controls plus the PC redirect. It also sequences pipeline drain on halt and flags a stuck branch wait.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 37 +++
 rtl/pipeline_hazard_ctrl_load_use_detect.sv | 22 ++
 rtl/pipeline_hazard_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and opcode constants for the pipeline hazard controller.
// Contents: opcode defines (guarded so any opcode header may predefine
// them), the per-stage control bundle, and an all-idle helper.
`ifndef I_TYPE_LOAD
`define I_TYPE_LOAD 7'b0000011
`endif
`ifndef B_TYPE
`define B_TYPE 7'b1100011
`endif
`ifndef S_TYPE
`define S_TYPE 7'b0100011
`endif

package pipeline_hazard_ctrl_pkg;

    localparam int unsigned OPC_W  = 7;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned ADDR_W = 32;

    localparam logic [OPC_W-1:0] OPC_LOAD = `I_TYPE_LOAD;

    // Per-stage pipeline controls driven every cycle.
    typedef struct packed {
        logic pc_stall;
        logic ifid_stall;
        logic ifid_flush;
        logic idex_bubble;
        logic back_stall;
        logic redirect_en;
    } hz_ctrl_t;

    // All controls inactive.
    function automatic hz_ctrl_t ctrl_idle();
        return hz_ctrl_t'('0);
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Load-use hazard comparator: a load in Exec whose destination feeds a
// source register actually read by the instruction in Dec.
// Ports: opcode_exec_i/rd_exec_i (Exec load), rs1/rs2_dec_i with their
// use flags (Dec consumer), load_use_o (combinational hazard flag).
module load_use_detect
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic [OPC_W-1:0] opcode_exec_i,
    input  logic [REG_W-1:0] rd_exec_i,
    input  logic [REG_W-1:0] rs1_dec_i,
    input  logic [REG_W-1:0] rs2_dec_i,
    input  logic             use_rs1_i,
    input  logic             use_rs2_i,
    output logic             load_use_o
);

    // x0 never carries a hazard.
    assign load_use_o = (opcode_exec_i == OPC_LOAD) && (rd_exec_i != '0) &&
                        ((use_rs1_i && (rd_exec_i == rs1_dec_i)) ||
                         (use_rs2_i && (rd_exec_i == rs2_dec_i)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush scheduler for the 5-stage RV32 pipeline.
// Inputs: mem_busy, wait_signal_c, npc_control/jump_target_PC, halt_Dec,
//         Dec source regs + use flags, Exec Rd/opcode.
// Outputs: pc_stall, ifid_stall, ifid_flush, idex_bubble, back_stall,
//          pc_redirect_en/target (combinational, act at next edge),
//          halted, hang_err (registered, sticky), cycle/stall/flush_cnt.
// Option: define PERF_CNT_EN to build the performance counters; otherwise
//         the counter ports are tied to zero.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = 4,
    parameter int unsigned MAX_BR_WAIT  = 8,
    parameter int unsigned CNT_W        = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_busy,
    input  logic              wait_signal_c,
    input  logic              npc_control,
    input  logic [ADDR_W-1:0] jump_target_PC,
    input  logic              halt_Dec,
    input  logic [REG_W-1:0]  Rsrc1_Dec,
    input  logic [REG_W-1:0]  Rsrc2_Dec,
    input  logic              use_rs1_Dec,
    input  logic              use_rs2_Dec,
    input  logic [REG_W-1:0]  Rd_Exec,
    input  logic [OPC_W-1:0]  opcode_Exec,
    output logic              pc_stall,
    output logic              ifid_stall,
    output logic              ifid_flush,
    output logic              idex_bubble,
    output logic              back_stall,
    output logic              pc_redirect_en,
    output logic [ADDR_W-1:0] pc_redirect_target,
    output logic              halted,
    output logic              hang_err,
    output logic [CNT_W-1:0]  cycle_cnt,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam int unsigned DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam int unsigned BRW_W   = $clog2(MAX_BR_WAIT + 1);

    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_HALTED} state_e;

    state_e              state_q, state_d;
    logic [DRAIN_W-1:0]  drain_cnt_q, drain_cnt_d;
    logic [BRW_W-1:0]    br_wait_q, br_wait_d;
    logic                halted_q, halted_d;
    logic                hang_err_q, hang_err_d;
    hz_ctrl_t            ctrl;
    logic [ADDR_W-1:0]   redirect_target;
    logic                load_use;

    load_use_detect u_load_use_detect (
        .opcode_exec_i (opcode_Exec),
        .rd_exec_i     (Rd_Exec),
        .rs1_dec_i     (Rsrc1_Dec),
        .rs2_dec_i     (Rsrc2_Dec),
        .use_rs1_i     (use_rs1_Dec),
        .use_rs2_i     (use_rs2_Dec),
        .load_use_o    (load_use)
    );

    // State, drain counter and sticky status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            drain_cnt_q <= '0;
            br_wait_q   <= '0;
            halted_q    <= 1'b0;
            hang_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            br_wait_q   <= br_wait_d;
            halted_q    <= halted_d;
            hang_err_q  <= hang_err_d;
        end
    end

    // Next state and per-stage controls; earlier RUN branches win.
    always_comb begin
        state_d         = state_q;
        drain_cnt_d     = drain_cnt_q;
        halted_d        = halted_q;
        ctrl            = ctrl_idle();
        redirect_target = '0;
        unique case (state_q)
            ST_RUN: begin
                if (mem_busy) begin
                    ctrl.pc_stall   = 1'b1;
                    ctrl.ifid_stall = 1'b1;
                    ctrl.back_stall = 1'b1;
                end else if (load_use || wait_signal_c) begin
                    ctrl.pc_stall    = 1'b1;
                    ctrl.ifid_stall  = 1'b1;
                    ctrl.idex_bubble = 1'b1;
                end else if (npc_control) begin
                    ctrl.redirect_en = 1'b1;
                    ctrl.ifid_flush  = 1'b1;
                    redirect_target  = jump_target_PC;
                end else if (halt_Dec) begin
                    // Halt itself moves on into Exec; fetch stops behind it.
                    ctrl.pc_stall   = 1'b1;
                    ctrl.ifid_flush = 1'b1;
                    state_d         = ST_DRAIN;
                    drain_cnt_d     = DRAIN_W'(DRAIN_CYCLES - 1);
                end
            end
            ST_DRAIN: begin
                ctrl.pc_stall   = 1'b1;
                ctrl.ifid_flush = 1'b1;
                if (mem_busy) begin
                    ctrl.back_stall = 1'b1;
                end else if (drain_cnt_q == '0) begin
                    state_d  = ST_HALTED;
                    halted_d = 1'b1;
                end else begin
                    drain_cnt_d = drain_cnt_q - DRAIN_W'(1);
                end
            end
            ST_HALTED: begin
                ctrl.pc_stall   = 1'b1;
                ctrl.ifid_stall = 1'b1;
                ctrl.back_stall = 1'b1;
            end
            default: state_d = ST_RUN;
        endcase
        if (rst) begin
            ctrl            = ctrl_idle();
            redirect_target = '0;
        end
    end

    // Branch-wait watchdog: counts unstalled RUN wait cycles, saturating.
    always_comb begin
        br_wait_d  = br_wait_q;
        hang_err_d = hang_err_q;
        if (!wait_signal_c) begin
            br_wait_d = '0;
        end else if ((state_q == ST_RUN) && !mem_busy &&
                     (br_wait_q != BRW_W'(MAX_BR_WAIT))) begin
            br_wait_d = br_wait_q + BRW_W'(1);
        end
        if (br_wait_d == BRW_W'(MAX_BR_WAIT)) begin
            hang_err_d = 1'b1;
        end
    end

    assign pc_stall           = ctrl.pc_stall;
    assign ifid_stall         = ctrl.ifid_stall;
    assign ifid_flush         = ctrl.ifid_flush;
    assign idex_bubble        = ctrl.idex_bubble;
    assign back_stall         = ctrl.back_stall;
    assign pc_redirect_en     = ctrl.redirect_en;
    assign pc_redirect_target = redirect_target;
    assign halted             = halted_q;
    assign hang_err           = hang_err_q;

`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] cycle_cnt_q, stall_cnt_q, flush_cnt_q;

    // Wrapping performance counters; stall/flush count RUN cycles only.
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt_q <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
            if ((state_q == ST_RUN) && ctrl.pc_stall) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if ((state_q == ST_RUN) && ctrl.ifid_flush) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end

    assign cycle_cnt = cycle_cnt_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign cycle_cnt = '0;
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios followed
// by randomized traffic, all compared each cycle against a behavioural model.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned DRAIN_CYCLES = 4;
    localparam int unsigned MAX_BR_WAIT  = 8;
    localparam int unsigned CNT_W        = 32;
    localparam logic [6:0]  OPC_LD       = 7'b0000011;
    localparam logic [6:0]  OPC_ALU      = 7'b0110011;

    logic        clk;
    logic        rst;
    logic        mem_busy;
    logic        wait_signal_c;
    logic        npc_control;
    logic [31:0] jump_target_PC;
    logic        halt_Dec;
    logic [4:0]  Rsrc1_Dec, Rsrc2_Dec, Rd_Exec;
    logic        use_rs1_Dec, use_rs2_Dec;
    logic [6:0]  opcode_Exec;
    logic        pc_stall, ifid_stall, ifid_flush, idex_bubble, back_stall;
    logic        pc_redirect_en;
    logic [31:0] pc_redirect_target;
    logic        halted, hang_err;
    logic [CNT_W-1:0] cycle_cnt, stall_cnt, flush_cnt;

    pipeline_hazard_ctrl #(
        .DRAIN_CYCLES (DRAIN_CYCLES),
        .MAX_BR_WAIT  (MAX_BR_WAIT),
        .CNT_W        (CNT_W)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .mem_busy           (mem_busy),
        .wait_signal_c      (wait_signal_c),
        .npc_control        (npc_control),
        .jump_target_PC     (jump_target_PC),
        .halt_Dec           (halt_Dec),
        .Rsrc1_Dec          (Rsrc1_Dec),
        .Rsrc2_Dec          (Rsrc2_Dec),
        .use_rs1_Dec        (use_rs1_Dec),
        .use_rs2_Dec        (use_rs2_Dec),
        .Rd_Exec            (Rd_Exec),
        .opcode_Exec        (opcode_Exec),
        .pc_stall           (pc_stall),
        .ifid_stall         (ifid_stall),
        .ifid_flush         (ifid_flush),
        .idex_bubble        (idex_bubble),
        .back_stall         (back_stall),
        .pc_redirect_en     (pc_redirect_en),
        .pc_redirect_target (pc_redirect_target),
        .halted             (halted),
        .hang_err           (hang_err),
        .cycle_cnt          (cycle_cnt),
        .stall_cnt          (stall_cnt),
        .flush_cnt          (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", tag, got, exp, $time);
        else
            n_pass++;
    endtask

    // Behavioural model: phase flags, remaining drain cycles, wait streak.
    bit          m_draining, m_halted, m_hang;
    int          m_drain_left, m_wait_run;
    logic [31:0] m_cyc, m_stall, m_flush;

    task automatic model_reset();
        m_draining = 0; m_halted = 0; m_hang = 0;
        m_drain_left = 0; m_wait_run = 0;
        m_cyc = '0; m_stall = '0; m_flush = '0;
    endtask

    task automatic idle();
        rst = 0; mem_busy = 0; wait_signal_c = 0; npc_control = 0;
        jump_target_PC = '0; halt_Dec = 0;
        Rsrc1_Dec = '0; Rsrc2_Dec = '0; Rd_Exec = '0;
        use_rs1_Dec = 0; use_rs2_Dec = 0; opcode_Exec = OPC_ALU;
    endtask

    // One clock: called at negedge with inputs set; checks, advances model.
    task automatic step();
        bit lu, running, e_pc, e_is, e_fl, e_bb, e_bs, e_re, go_halt;
        logic [31:0] e_tgt;
        #1;
        lu = (opcode_Exec == OPC_LD) && (Rd_Exec != 0) &&
             ((use_rs1_Dec && Rd_Exec == Rsrc1_Dec) || (use_rs2_Dec && Rd_Exec == Rsrc2_Dec));
        running = !m_draining && !m_halted;
        {e_pc, e_is, e_fl, e_bb, e_bs, e_re} = '0;
        e_tgt = '0;
        go_halt = 0;
        if (!rst) begin
            if (m_halted) begin
                e_pc = 1; e_is = 1; e_bs = 1;
            end else if (m_draining) begin
                e_pc = 1; e_fl = 1; e_bs = mem_busy;
            end else if (mem_busy) begin
                e_pc = 1; e_is = 1; e_bs = 1;
            end else if (lu || wait_signal_c) begin
                e_pc = 1; e_is = 1; e_bb = 1;
            end else if (npc_control) begin
                e_re = 1; e_fl = 1; e_tgt = jump_target_PC;
            end else if (halt_Dec) begin
                e_pc = 1; e_fl = 1; go_halt = 1;
            end
        end
        check_eq("pc_stall",    32'(pc_stall),    32'(e_pc));
        check_eq("ifid_stall",  32'(ifid_stall),  32'(e_is));
        check_eq("ifid_flush",  32'(ifid_flush),  32'(e_fl));
        check_eq("idex_bubble", 32'(idex_bubble), 32'(e_bb));
        check_eq("back_stall",  32'(back_stall),  32'(e_bs));
        check_eq("redir_en",    32'(pc_redirect_en), 32'(e_re));
        check_eq("redir_tgt",   pc_redirect_target, e_tgt);
        check_eq("halted",      32'(halted),      32'(m_halted));
        check_eq("hang_err",    32'(hang_err),    32'(m_hang));
        check_eq("cycle_cnt",   32'(cycle_cnt),   m_cyc);
        check_eq("stall_cnt",   32'(stall_cnt),   m_stall);
        check_eq("flush_cnt",   32'(flush_cnt),   m_flush);
        if (rst) begin
            model_reset();
        end else begin
`ifdef PERF_CNT_EN
            m_cyc = m_cyc + 1;
            if (running) begin
                m_stall = m_stall + 32'(e_pc);
                m_flush = m_flush + 32'(e_fl);
            end
`endif
            if (!wait_signal_c) m_wait_run = 0;
            else if (running && !mem_busy && m_wait_run < int'(MAX_BR_WAIT)) m_wait_run++;
            if (m_wait_run == int'(MAX_BR_WAIT)) m_hang = 1;
            if (m_draining && !mem_busy) begin
                if (m_drain_left == 0) begin
                    m_draining = 0; m_halted = 1;
                end else begin
                    m_drain_left--;
                end
            end else if (go_halt) begin
                m_draining = 1; m_drain_left = int'(DRAIN_CYCLES) - 1;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle(); rst = 1; step(); idle();
    endtask

    int drain_len;
    int burst;

    initial begin
        idle();
        rst = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        model_reset();
        do_reset();

        // Load-use hits, then x0 destination does not stall.
        opcode_Exec = OPC_LD; Rd_Exec = 5'd5; Rsrc1_Dec = 5'd5; use_rs1_Dec = 1; step();
        idle(); step();
        opcode_Exec = OPC_LD; Rd_Exec = 5'd0; Rsrc1_Dec = 5'd0; use_rs1_Dec = 1; step();
        idle(); opcode_Exec = OPC_LD; Rd_Exec = 5'd7; Rsrc2_Dec = 5'd7; use_rs2_Dec = 1; step();

        // Redirect, then redirect masked by mem_busy.
        idle(); npc_control = 1; jump_target_PC = 32'h0000_0040; step();
        mem_busy = 1; step();

        // Wait beats redirect; redirect follows once wait drops.
        idle(); wait_signal_c = 1; npc_control = 1; jump_target_PC = 32'h0000_0080; step();
        wait_signal_c = 0; step();

        // Watchdog: 7-cycle streak stays clean, 8-cycle streak trips.
        idle(); wait_signal_c = 1; repeat (7) step();
        wait_signal_c = 0; step();
        check_eq("hang_after_7", 32'(hang_err), 32'(0));
        wait_signal_c = 1; repeat (8) step();
        check_eq("hang_after_8", 32'(hang_err), 32'(1));
        wait_signal_c = 0; repeat (3) step();
        check_eq("hang_sticky", 32'(hang_err), 32'(1));
        do_reset();

        // Plain halt drain length.
        halt_Dec = 1; step(); idle();
        drain_len = 0;
        while (!halted && drain_len < 20) begin step(); drain_len++; end
        check_eq("drain_len", 32'(drain_len), 32'(DRAIN_CYCLES));
        repeat (3) step();
        check_eq("halted_held", 32'(halted), 32'(1));
        do_reset();

        // Halt drain with two busy cycles inside it.
        halt_Dec = 1; step(); idle();
        step(); mem_busy = 1; step(); step(); mem_busy = 0;
        drain_len = 3;
        while (!halted && drain_len < 20) begin step(); drain_len++; end
        check_eq("drain_len_busy", 32'(drain_len), 32'(DRAIN_CYCLES + 2));

        // Reset from HALTED, then from mid-DRAIN.
        do_reset();
        step();
        halt_Dec = 1; step(); idle(); step();
        do_reset();
        step();

        // Randomized traffic.
        burst = 0;
        for (int i = 0; i < 3000; i++) begin
            rst      = ($urandom_range(0, 59) == 0);
            mem_busy = ($urandom_range(0, 4) == 0);
            if (burst > 0) begin
                wait_signal_c = 1; burst--;
            end else if ($urandom_range(0, 5) == 0) begin
                wait_signal_c = 1; burst = int'($urandom_range(0, 11));
            end else begin
                wait_signal_c = 0;
            end
            npc_control    = ($urandom_range(0, 3) == 0);
            jump_target_PC = $urandom;
            halt_Dec       = ($urandom_range(0, 39) == 0);
            Rsrc1_Dec      = 5'($urandom_range(0, 3));
            Rsrc2_Dec      = 5'($urandom_range(0, 3));
            Rd_Exec        = 5'($urandom_range(0, 3));
            use_rs1_Dec    = 1'($urandom_range(0, 1));
            use_rs2_Dec    = 1'($urandom_range(0, 1));
            opcode_Exec    = ($urandom_range(0, 1) == 1) ? OPC_LD : 7'($urandom);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
